// File: rtl/delay_sched.sv
// Round-robin scheduler for one shared delay counter.
// Up to NREQ clients request a timed wait of their own length. One owner at a time
// gets the counter; when its wait expires it receives a one-cycle done pulse. All
// outputs are registered, and a sticky err flag records any broken internal invariant.
module delay_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CBITS = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CBITS-1:0]   dly,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [CBITS-1:0]        cnt,
  output logic                    err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  logic [CBITS-1:0]  len_q, len_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;

  // Per-requester delay lengths unpacked from the flat input bus.
  logic [CBITS-1:0]  dly_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_dly
    assign dly_arr[g] = dly[g*CBITS +: CBITS];
  end

  // Round-robin pick: first active request after the previous owner, wrapping around.
  // The previous owner is searched last, so a held request gets lowest priority.
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  int unsigned   cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!pick_vld && req[IW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;

    unique case (state_q)
      StIdle: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pick_vld) begin
          gnt_d[pick_idx] = 1'b1;
          // Length is latched here; later changes on dly do not affect this wait.
          len_d    = dly_arr[pick_idx];
          busy_d   = 1'b1;
          owner_d  = pick_idx;
          rr_ptr_d = pick_idx;
          state_d  = StCount;
        end
      end

      StCount: begin
        if (!req[owner_q]) begin
          // Owner withdrew: abandon the wait silently. Takes priority over expiry.
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == len_q) begin
          done_d[owner_q] = 1'b1;
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_q < len_q) begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end

      StDone: begin
        // One mandatory idle pass before the next arbitration.
        state_d = StIdle;
      end

      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Invariant checks on the registered state; err stays set until reset.
  logic gnt_bad, done_bad, cnt_bad;

  always_comb begin
    gnt_bad  = busy_q && ((gnt_q == '0) || ((gnt_q & (gnt_q - NREQ'(1))) != '0));
    done_bad = (done_q & (done_q - NREQ'(1))) != '0;
    cnt_bad  = cnt_q > len_q;
    err_d    = err_q | gnt_bad | done_bad | cnt_bad;
  end

  // State register with asynchronous reset to the idle configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;
  assign err  = err_q;

endmodule
